// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: user-side session controller that drives cardhandling (card latch, PIN check, shadow-balance operations)
module atm_session_ctrl #(
   parameter int card_width     = 6,
   parameter int password_width = 16,
   parameter int balance_width  = 20,
   parameter int users_num      = 10,
   parameter int max_attempts   = 3,
   parameter int timeout_cycles = 1000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      card_inserted,
   input  logic [card_width-1:0]     card_id,
   input  logic [password_width-1:0] pin_entry,
   input  logic                      pin_valid,
   input  logic [1:0]                op_code,
   input  logic [balance_width-1:0]  amount,
   input  logic                      op_valid,
   input  logic                      cancel,
   input  logic [balance_width-1:0]  balance,
   input  logic                      wrong_psw,
   output logic [card_width-1:0]     card_number,
   output logic                      card_in,
   output logic [password_width-1:0] password_input,
   output logic                      op_done,
   output logic [balance_width-1:0]  updated_balance,
   output logic [balance_width-1:0]  balance_out,
   output logic                      op_ok,
   output logic                      insufficient,
   output logic                      overflow,
   output logic                      invalid_card,
   output logic                      card_ejected,
   output logic                      card_retained
);
   localparam int tw = $clog2(timeout_cycles + 1);
   localparam int aw = $clog2(max_attempts + 1);
   localparam logic [tw-1:0] t_last = tw'(timeout_cycles - 1);
   localparam logic [aw-1:0] a_max = aw'(max_attempts);
   typedef enum logic [3:0] {IDLE, WAIT_PIN, CHECK, EVAL, MENU, EXEC, WRITE, EJECT, RETAIN} state_t;
   state_t state, state_next;
   logic                     card_prev, card_rise, card_ok;
   logic [tw-1:0]            timer;
   logic [aw-1:0]            attempts, attempts_inc;
   logic [balance_width-1:0] shadow, new_bal, amount_r, result;
   logic [1:0]               op_r;
   logic [balance_width:0]   sum;
   logic                     wd_ok, dep_ok, accept, timed_out;
   // next-state decode, operation arithmetic and session outputs
   always_comb begin
      card_rise       = card_inserted & ~card_prev;
      card_ok         = 32'(card_id) < 32'(users_num);
      attempts_inc    = attempts + aw'(1);
      timed_out       = timer == t_last;
      sum             = {1'b0, shadow} + {1'b0, amount_r};
      wd_ok           = amount_r <= shadow;
      dep_ok          = ~sum[balance_width];
      accept          = (op_r == 2'b00) | ((op_r == 2'b01) & wd_ok) | ((op_r == 2'b10) & dep_ok);
      result          = (op_r == 2'b01) ? shadow - amount_r : (op_r == 2'b10) ? sum[balance_width-1:0] : shadow;
      card_in         = (state == CHECK) | (state == EVAL) | (state == MENU) | (state == EXEC) | (state == WRITE);
      op_done         = state == WRITE;
      updated_balance = (state == WRITE) ? new_bal : shadow;
      balance_out     = shadow;
      op_ok           = (state == EXEC) & accept;
      insufficient    = (state == EXEC) & (op_r == 2'b01) & ~wd_ok;
      overflow        = (state == EXEC) & (op_r == 2'b10) & ~dep_ok;
      card_ejected    = state == EJECT;
      card_retained   = state == RETAIN;
      state_next      = state;
      case (state)
         IDLE:     state_next = card_rise ? (card_ok ? WAIT_PIN : EJECT) : IDLE;
         WAIT_PIN: state_next = cancel ? EJECT : pin_valid ? CHECK : timed_out ? EJECT : WAIT_PIN;
         CHECK:    state_next = EVAL;
         EVAL:     state_next = !wrong_psw ? MENU : (attempts_inc == a_max) ? RETAIN : WAIT_PIN;
         MENU:     state_next = cancel ? EJECT : op_valid ? (op_code == 2'b11 ? EJECT : EXEC) : timed_out ? EJECT : MENU;
         EXEC:     state_next = accept ? WRITE : MENU;
         WRITE:    state_next = MENU;
         default:  state_next = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end
   // card edge detect, idle timer and attempt counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         card_prev    <= 1'b0;
         invalid_card <= 1'b0;
         timer        <= '0;
         attempts     <= '0;
      end else begin
         card_prev    <= card_inserted;
         invalid_card <= (state == IDLE) & card_rise & ~card_ok;
         timer        <= (state == state_next && (state == WAIT_PIN || state == MENU)) ? timer + tw'(1) : '0;
         if (state == IDLE) attempts <= '0;
         else if (state == EVAL && wrong_psw) attempts <= attempts_inc;
      end
   end
   // latched card, PIN and pending operation
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         card_number    <= '0;
         password_input <= '0;
         op_r           <= '0;
         amount_r       <= '0;
      end else begin
         if (state == IDLE && card_rise) card_number <= card_id;
         if (state == WAIT_PIN && !cancel && pin_valid) password_input <= pin_entry;
         if (state == MENU && !cancel && op_valid) begin
            op_r     <= op_code;
            amount_r <= amount;
         end
      end
   end
   // shadow balance: cleared when idle, loaded after a good PIN, updated on write-back
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow  <= '0;
         new_bal <= '0;
      end else begin
         if (state == EXEC) new_bal <= result;
         shadow <= (state == IDLE) ? '0 : (state == EVAL && !wrong_psw) ? balance : (state == WRITE) ? new_bal : shadow;
      end
   end
endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl: scoreboard bench with a cardhandling model and a session-level reference model
module tb_atm_session_ctrl;
   localparam int max_bal = (1 << 20) - 1;
   localparam int tmo = 8;
   localparam logic [6:0] e_done = 7'b1000000, e_ok = 7'b0100000, e_ins = 7'b0010000, e_ovf = 7'b0001000;
   localparam logic [6:0] e_inv = 7'b0000100, e_ej = 7'b0000010, e_ret = 7'b0000001;
   logic        clk = 0, rst = 0;
   logic        card_inserted = 0, pin_valid = 0, op_valid = 0, cancel = 0, wrong_psw = 0;
   logic [5:0]  card_id = 0, card_number;
   logic [15:0] pin_entry = 0, password_input;
   logic [1:0]  op_code = 0;
   logic [19:0] amount = 0, balance, updated_balance, balance_out;
   logic        card_in, op_done, op_ok, insufficient, overflow, invalid_card, card_ejected, card_retained;
   atm_session_ctrl #(.timeout_cycles(tmo)) dut (
      .clk(clk), .rst(rst), .card_inserted(card_inserted), .card_id(card_id), .pin_entry(pin_entry),
      .pin_valid(pin_valid), .op_code(op_code), .amount(amount), .op_valid(op_valid), .cancel(cancel),
      .balance(balance), .wrong_psw(wrong_psw), .card_number(card_number), .card_in(card_in),
      .password_input(password_input), .op_done(op_done), .updated_balance(updated_balance),
      .balance_out(balance_out), .op_ok(op_ok), .insufficient(insufficient), .overflow(overflow),
      .invalid_card(invalid_card), .card_ejected(card_ejected), .card_retained(card_retained));
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc++;
   // cardhandling model: account memory written back by the DUT, registered PIN check
   logic [15:0] pin_tab [16];
   logic [19:0] ch_acct [16];
   logic        ld_en = 0;
   logic [3:0]  ld_idx = 0;
   logic [19:0] ld_val = 0;
   assign balance = ch_acct[card_number[3:0]];
   always @(posedge clk) begin
      wrong_psw <= password_input != pin_tab[card_number[3:0]];
      if (ld_en) ch_acct[ld_idx] <= ld_val;
      else if (op_done && card_in) ch_acct[card_number[3:0]] <= updated_balance;
   end
   typedef struct packed {logic [6:0] ev; logic [19:0] upd; logic [19:0] bal;} exp_t;
   exp_t q[$];
   exp_t e;
   int tests = 0, fails = 0;
   int done_cyc = -1, eject_cyc = -1;
   bit card_in_seen = 0;
   logic [6:0] act;
   // monitor: every cycle showing a pulse consumes one expected event
   always @(negedge clk) begin
      act = {op_done, op_ok, insufficient, overflow, invalid_card, card_ejected, card_retained};
      if (card_in) card_in_seen = 1;
      if (rst && act != 0) begin
         if (act[6]) done_cyc = cyc;
         if (act[1]) eject_cyc = cyc;
         tests++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event got ev=%b upd=%0d bal=%0d", act, updated_balance, balance_out);
         end else begin
            e = q.pop_front();
            if (e.ev !== act || e.upd !== updated_balance || e.bal !== balance_out) begin
               fails++;
               $display("FAIL event got ev=%b upd=%0d bal=%0d expected ev=%b upd=%0d bal=%0d",
                        act, updated_balance, balance_out, e.ev, e.upd, e.bal);
            end
         end
      end
   end
   task automatic check(string name, int got, int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask
   // reference model of one session
   int  ref_acct [16];
   int  ref_id, ref_att, ref_s;
   bit  ref_live = 0, ref_menu = 0;
   function automatic void push(logic [6:0] ev, int upd, int bal);
      q.push_back({ev, upd[19:0], bal[19:0]});
   endfunction
   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic set_acct(int i, int v);
      ref_acct[i] = v;
      ld_idx = 4'(i); ld_val = 20'(v); ld_en = 1;
      tick(1);
      ld_en = 0;
   endtask
   task automatic insert(int id);
      card_id = 6'(id); card_inserted = 1;
      ref_id = id; ref_att = 0; ref_s = 0; ref_menu = 0; ref_live = id < 10;
      if (!ref_live) push(e_inv | e_ej, 0, 0);
      tick(3);
   endtask
   task automatic remove();
      card_inserted = 0;
      ref_live = 0; ref_menu = 0;
      tick(2);
   endtask
   task automatic pin(logic [15:0] p);
      if (ref_live && !ref_menu) begin
         if (p == pin_tab[ref_id]) begin
            ref_menu = 1;
            ref_s = ref_acct[ref_id];
         end else begin
            ref_att++;
            if (ref_att == 3) begin
               push(e_ret, ref_s, ref_s);
               ref_live = 0;
            end
         end
      end
      pin_entry = p; pin_valid = 1;
      tick(1);
      pin_valid = 0;
      tick(4);
   endtask
   task automatic model_op(logic [1:0] c, int a);
      int n;
      if (!(ref_live && ref_menu)) return;
      n = (c == 2'd1) ? ref_s - a : ref_s + a;
      if (c == 2'd3) begin
         push(e_ej, ref_s, ref_s);
         ref_live = 0; ref_menu = 0;
      end else if (c == 2'd1 && a > ref_s) push(e_ins, ref_s, ref_s);
      else if (c == 2'd2 && n > max_bal) push(e_ovf, ref_s, ref_s);
      else begin
         if (c == 2'd0) n = ref_s;
         push(e_ok, ref_s, ref_s);
         push(e_done, n, ref_s);
         ref_s = n;
         ref_acct[ref_id] = n;
      end
   endtask
   task automatic op(logic [1:0] c, int a, bit settle = 1);
      model_op(c, a);
      op_code = c; amount = 20'(a); op_valid = 1;
      tick(1);
      op_valid = 0;
      if (settle) tick(4);
   endtask
   task automatic abort(bit with_op);
      if (ref_live) begin
         push(e_ej, ref_s, ref_s);
         ref_live = 0; ref_menu = 0;
      end
      cancel = 1; op_valid = with_op; op_code = 2'd1; amount = 20'd1;
      tick(1);
      cancel = 0; op_valid = 0;
      tick(4);
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      int n, t0, id, a;
      logic [1:0] c;
      for (int i = 0; i < 16; i++) pin_tab[i] = 16'h1000 + 16'(i * 37);
      pin_tab[3] = 16'h1234;
      tick(3);
      check("reset_card_in", card_in, 0);
      check("reset_updated_balance", updated_balance, 0);
      check("reset_balance_out", balance_out, 0);
      check("reset_pulses", {op_done, op_ok, insufficient, overflow, invalid_card, card_ejected, card_retained}, 0);
      rst = 1;
      for (int i = 0; i < 16; i++) set_acct(i, (i % 3 == 0) ? max_bal - int'($urandom_range(1, 50)) : int'($urandom_range(0, 5000)));
      set_acct(3, 500);
      insert(3); pin(16'h1234); op(1, 200); op(0, 0);
      check("balance_out_after_withdraw", balance_out, 300);
      op(3, 0); remove();
      check("account_written_back", ch_acct[3], 300);
      insert(3); pin(16'h0001); pin(16'h0002); pin(16'h0003); remove();
      insert(3); pin(16'h0004); pin(16'h1234); op(3, 0); remove();
      insert(3); pin(16'h0005); pin(16'h0006); pin(16'h1234); op(0, 0); op(3, 0); remove();
      set_acct(3, 100);
      insert(3); pin(16'h1234); op(1, 101);
      check("balance_out_after_refusal", balance_out, 100);
      op(0, 0); op(3, 0); remove();
      set_acct(5, max_bal - 9);
      insert(5); pin(pin_tab[5]); op(2, 10); op(2, 9); op(3, 0); remove();
      check("deposit_to_max", ch_acct[5], max_bal);
      card_in_seen = 0;
      insert(12); remove();
      check("invalid_card_no_card_in", int'(card_in_seen), 0);
      check("invalid_card_latched", card_number, 12);
      insert(4); pin(pin_tab[4]);
      t0 = eject_cyc;
      op(0, 0, 0);
      push(e_ej, ref_s, ref_s); ref_live = 0;
      n = 0;
      while (eject_cyc == t0 && n < 40) begin tick(1); n++; end
      check("menu_timeout_cycles", eject_cyc - done_cyc, tmo + 1);
      remove();
      insert(3); pin(16'h1234); abort(1); remove();
      check("cancel_beats_op", ch_acct[3], 100);
      insert(3); pin(16'h1234);
      push(e_ok, ref_s, ref_s);
      op_code = 2'd1; amount = 20'd50; op_valid = 1;
      tick(1);
      op_valid = 0;
      n = 0;
      while (!op_done && n < 10) begin tick(1); n++; end
      rst = 0; card_inserted = 0; ref_live = 0; ref_menu = 0;
      #1;
      check("async_reset_op_done", op_done, 0);
      check("async_reset_card_in", card_in, 0);
      check("async_reset_updated_balance", updated_balance, 0);
      check("async_reset_balance_out", balance_out, 0);
      check("async_reset_password", password_input, 0);
      tick(2);
      rst = 1;
      tick(2);
      check("reset_abandons_write", ch_acct[3], 100);
      for (int s = 0; s < 30; s++) begin
         id = int'($urandom_range(0, 11));
         insert(id);
         for (int k = 0; k < 3 && ref_live && !ref_menu; k++)
            pin(($urandom_range(0, 2) != 0) ? pin_tab[id] : pin_tab[id] ^ 16'($urandom_range(1, 65535)));
         if (ref_menu) begin
            n = int'($urandom_range(1, 5));
            for (int k = 0; k < n; k++) begin
               c = 2'($urandom_range(0, 2));
               a = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 60)) : int'($urandom_range(0, max_bal));
               op(c, a);
            end
            if ($urandom_range(0, 1) != 0) op(3, 0);
            else abort($urandom_range(0, 1) != 0);
         end
         remove();
      end
      tick(10);
      check("scoreboard_drained", q.size(), 0);
      for (int i = 0; i < 10; i++) check("final_account", ch_acct[i], ref_acct[i]);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
